// File: rtl/pinwheel_mmio_pkg.sv
// Shared types, register map and helpers for the pinwheel MMIO block.
package pinwheel_mmio_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam logic [3:0] OFF_TXDATA = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_DIV    = 4'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_COUNT  = 8;

    localparam logic [3:0] DEFAULT_DEBUG_TAG  = 4'hF;
    localparam logic [3:0] DEFAULT_SERIAL_TAG = 4'hC;

    localparam logic [15:0] DIV_MIN = 16'd2;

    // A divisor below 2 cannot produce a distinct bit period, so it is raised.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/pinwheel_mmio_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PTR_ONE;
            if (pop_ok)  rd_q <= rd_q + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/pinwheel_mmio.sv
// Pinwheel MMIO peripheral: tag-decoded debug register bank and FIFO-fed 8N1 transmitter.
module pinwheel_mmio
    import pinwheel_mmio_pkg::*;
#(
    parameter int         DEBUG_WORDS  = 4,
    parameter int         FIFO_DEPTH   = 8,
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [3:0] DEBUG_TAG    = DEFAULT_DEBUG_TAG,
    parameter logic [3:0] SERIAL_TAG   = DEFAULT_SERIAL_TAG
) (
    input  logic        clock,
    input  logic        tick_reset_in,
    input  logic [31:0] tick_bus_addr,
    input  logic        tick_bus_rden,
    input  logic        tick_bus_wren,
    input  logic [31:0] tick_bus_wdata,
    input  logic [3:0]  tick_bus_wmask,
    output logic [31:0] rdata_ret,
    output logic        hit_ret,
    output logic        serial_tx,
    output logic        serial_busy,
    output logic [31:0] debug_out
);
    localparam int IDX_W = (DEBUG_WORDS > 1) ? $clog2(DEBUG_WORDS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       tag;
    logic [3:0]       widx;
    logic             dbg_sel;
    logic             ser_sel;
    logic [IDX_W-1:0] dbg_idx;
    logic             unused_addr;

    assign tag         = tick_bus_addr[31:28];
    assign widx        = tick_bus_addr[5:2];
    assign dbg_sel     = (tag == DEBUG_TAG);
    assign ser_sel     = (tag == SERIAL_TAG) && !dbg_sel;
    assign dbg_idx     = IDX_W'(32'(widx) % DEBUG_WORDS);
    assign unused_addr = ^{tick_bus_addr[27:6], tick_bus_addr[1:0]};

    logic [31:0] dbg_q [DEBUG_WORDS];

    always_ff @(posedge clock) begin
        if (tick_reset_in) begin
            for (int i = 0; i < DEBUG_WORDS; i++) dbg_q[i] <= '0;
        end else if (tick_bus_wren && dbg_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (tick_bus_wmask[b]) dbg_q[dbg_idx][8*b +: 8] <= tick_bus_wdata[8*b +: 8];
            end
        end
    end

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [7:0]       head;
    logic [CNT_W-1:0] count;
    logic             status_wr;
    logic             div_wr;
    tx_state_t        state_q;

    assign push      = tick_bus_wren && ser_sel && (widx == OFF_TXDATA);
    assign status_wr = tick_bus_wren && ser_sel && (widx == OFF_STATUS);
    assign div_wr    = tick_bus_wren && ser_sel && (widx == OFF_DIV);
    // Pop is gated on the registered count, so a byte pushed this edge waits one cycle.
    assign pop       = (state_q == TX_IDLE) && (count != '0);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clock),
        .rst_i   (tick_reset_in),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (tick_bus_wdata[7:0]),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    logic        tx_q;
    logic [7:0]  shift_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [15:0] div_q;
    logic        bit_done;

    assign bit_done = (cnt_q == 16'd1);

    // Bit counter reloads from div_q only at bit boundaries, so DIV writes never stretch a bit in flight.
    always_ff @(posedge clock) begin
        if (tick_reset_in) begin
            state_q <= TX_IDLE;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        state_q <= TX_START;
                        tx_q    <= 1'b0;
                        shift_q <= head;
                        cnt_q   <= div_q;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        state_q <= TX_DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= 3'd0;
                        cnt_q   <= div_q;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        cnt_q <= div_q;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_done) state_q <= TX_IDLE;
                    else          cnt_q   <= cnt_q - 16'd1;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    logic        ovf_q;
    logic        busy_q;
    logic        busy_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        hit_q;
    logic        hit_d;
    logic [31:0] status;

    assign busy_d = (count != '0) || push ||
                    ((state_q != TX_IDLE) && !((state_q == TX_STOP) && bit_done));

    always_comb begin
        status                 = '0;
        status[ST_FULL]        = full;
        status[ST_EMPTY]       = empty;
        status[ST_ACTIVE]      = (state_q != TX_IDLE);
        status[ST_OVF]         = ovf_q;
        status[ST_COUNT +: 8]  = 8'(count);
    end

    // Read data comes from pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        hit_d   = tick_bus_rden && (dbg_sel || ser_sel);
        if (tick_bus_rden && dbg_sel) begin
            rdata_d = dbg_q[dbg_idx];
        end else if (tick_bus_rden && ser_sel) begin
            case (widx)
                OFF_STATUS: rdata_d = status;
                OFF_DIV:    rdata_d = {16'h0000, div_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tick_reset_in) begin
            div_q   <= 16'(CLKS_PER_BIT);
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            if (push && full && !pop)                        ovf_q <= 1'b1;
            else if (status_wr && tick_bus_wdata[ST_OVF])    ovf_q <= 1'b0;
            if (div_wr) div_q <= clamp_div(tick_bus_wdata[15:0]);
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign rdata_ret   = rdata_q;
    assign hit_ret     = hit_q;
    assign serial_tx   = tx_q;
    assign serial_busy = busy_q;
    assign debug_out   = dbg_q[0];

endmodule

// File: tb/tb_pinwheel_mmio.sv
// Directed-plus-random bench for pinwheel_mmio with a line-level UART receiver model.
module tb_pinwheel_mmio;

    localparam int          DEPTH   = 8;
    localparam int          DEF_DIV = 16;
    localparam logic [31:0] A_TX    = 32'hC000_0000;
    localparam logic [31:0] A_ST    = 32'hC000_0004;
    localparam logic [31:0] A_DIV   = 32'hC000_0008;

    logic        clock;
    logic        rst;
    logic [31:0] addr;
    logic        rden;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        busy;
    logic [31:0] dbg;

    pinwheel_mmio #(
        .DEBUG_WORDS(4), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(DEF_DIV),
        .DEBUG_TAG(4'hF), .SERIAL_TAG(4'hC)
    ) dut (
        .clock(clock), .tick_reset_in(rst), .tick_bus_addr(addr),
        .tick_bus_rden(rden), .tick_bus_wren(wren), .tick_bus_wdata(wdata),
        .tick_bus_wmask(wmask), .rdata_ret(rdata), .hit_ret(hit),
        .serial_tx(tx), .serial_busy(busy), .debug_out(dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time bound exceeded");
        $fatal(1, "timeout");
    end

    int errors = 0;
    int checks = 0;
    logic txlog[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        txlog.push_back(tx);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; wren = 1'b1; rden = 1'b0;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr = a; rden = 1'b1; wren = 1'b0;
        tick();
        rden = 1'b0;
        d = rdata;
        h = hit;
    endtask

    // Bit j of an 8N1 frame: start, eight data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    logic [31:0] rv;
    logic        rh;
    logic [31:0] model [4];
    logic [31:0] a, d;
    logic [3:0]  m;
    logic [7:0]  rxb;
    logic [63:0] got, expv;
    logic [7:0]  exp_q[$];
    int          dv, pos, zeros, idx, cntv, k, len;

    initial begin
        rst = 1'b1; addr = '0; rden = 1'b0; wren = 1'b0; wdata = '0; wmask = '0;
        tick(); tick();
        check("rst_rdata", rdata, 0);
        check("rst_hit", hit, 0);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_debug_out", dbg, 0);
        rst = 1'b0;

        rd(A_ST, rv, rh);
        check("status_after_reset", rv, 32'h2);
        check("status_hit", rh, 1);
        check("idle_tx", tx, 1);
        rd(32'h0000_0004, rv, rh);
        check("unsel_rdata", rv, 0);
        check("unsel_hit", rh, 0);
        rd(32'hC000_000C, rv, rh);
        check("ser_undef_rdata", rv, 0);
        check("ser_undef_hit", rh, 1);
        rd(A_TX, rv, rh);
        check("txdata_read", rv, 0);

        // Byte-masked debug write and aliasing by word index modulo bank size
        wr(32'hF000_0004, 32'hDEAD_BEEF, 4'b0011);
        rd(32'hF000_0004, rv, rh);
        check("dbg_mask", rv, 32'h0000_BEEF);
        check("dbg_out_untouched", dbg, 0);
        rd(32'hF000_0014, rv, rh);
        check("dbg_alias", rv, 32'h0000_BEEF);

        model[0] = '0; model[1] = 32'h0000_BEEF; model[2] = '0; model[3] = '0;
        repeat (24) begin
            a = {4'hF, 22'($urandom), 4'($urandom_range(15)), 2'($urandom)};
            d = $urandom;
            m = 4'($urandom);
            wr(a, d, m);
            idx = int'(a[5:2]) % 4;
            for (int b = 0; b < 4; b++) if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            check("dbg_out_rand", dbg, model[0]);
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'hF000_0000 + 32'(4*i), rv, rh);
            check("dbg_rand_readback", rv, model[i]);
        end

        addr = 32'hF000_0008; rden = 1'b1; wren = 1'b1; wdata = 32'h1234_5678; wmask = 4'hF;
        tick();
        rden = 1'b0; wren = 1'b0;
        check("rw_same_old", rdata, model[2]);
        model[2] = 32'h1234_5678;
        rd(32'hF000_0008, rv, rh);
        check("rw_same_new", rv, model[2]);

        // Single frame at DIV=4
        wr(A_DIV, 32'd4, 4'h0);
        txlog.delete();
        wr(A_TX, 32'hA5, 4'h0);
        check("push_tx_still_idle", tx, 1);
        check("push_busy", busy, 1);
        repeat (40) tick();
        got = '0; expv = '0;
        for (int i = 0; i < 40; i++) begin
            got[i]  = txlog[1+i];
            expv[i] = frame_bit(8'hA5, i / 4);
        end
        check("frame_A5", got, expv);
        check("busy_last_stop_cycle", busy, 1);
        tick();
        check("busy_drop", busy, 0);
        check("tx_idle_after", tx, 1);

        // Random back-to-back frames decoded by sampling bit centres
        dv = $urandom_range(2, 5);
        wr(A_DIV, 32'(dv), 4'h0);
        txlog.delete(); exp_q.delete();
        for (int f = 0; f < 5; f++) begin
            rxb = 8'($urandom);
            exp_q.push_back(rxb);
            wr(A_TX, {24'h0, rxb}, 4'h0);
        end
        repeat (5 * (10 * dv + 1) + 20) tick();
        pos = 0;
        for (int f = 0; f < 5; f++) begin
            while (pos < txlog.size() && txlog[pos] !== 1'b0) pos++;
            check("rx_start_pos", pos, 1 + f * (10 * dv + 1));
            if (pos + 10 * dv <= txlog.size()) begin
                for (int j = 1; j <= 8; j++) rxb[j-1] = txlog[pos + j * dv + dv / 2];
                check("rx_byte", rxb, exp_q[f]);
                check("rx_stop", txlog[pos + 9 * dv + dv / 2], 1);
                pos = pos + 10 * dv;
            end
        end
        zeros = 0;
        for (int i = pos; i < txlog.size(); i++) if (txlog[i] !== 1'b1) zeros++;
        check("rx_tail_idle", zeros, 0);
        check("rx_busy_done", busy, 0);

        // Overflow with the line stalled by a huge divisor
        wr(A_DIV, 32'hFFFF, 4'h0);
        for (int i = 0; i < 10; i++) wr(A_TX, 32'(i), 4'h0);
        cntv = (10 - 1 > DEPTH) ? DEPTH : 10 - 1;
        expv = 64'((cntv << 8) | (((10 - 1) > DEPTH) ? 8 : 0) | 4 | ((cntv == DEPTH) ? 1 : 0));
        rd(A_ST, rv, rh);
        check("ovf_status", rv, expv);
        wr(A_ST, 32'h7, 4'h0);
        rd(A_ST, rv, rh);
        check("ovf_not_cleared", rv, expv);
        wr(A_ST, 32'h8, 4'h0);
        rd(A_ST, rv, rh);
        check("ovf_cleared", rv, expv & ~64'h8);
        rst = 1'b1; tick(); rst = 1'b0;
        check("ovf_reset_tx", tx, 1);
        rd(A_ST, rv, rh);
        check("ovf_reset_status", rv, 32'h2);

        // DIV clamp and readback
        wr(A_DIV, 32'd1, 4'h0);
        rd(A_DIV, rv, rh);
        check("div_clamp_1", rv, 2);
        wr(A_DIV, 32'd0, 4'h0);
        rd(A_DIV, rv, rh);
        check("div_clamp_0", rv, 2);
        dv = $urandom_range(2, 65535);
        wr(A_DIV, 32'(dv), 4'h0);
        addr = A_DIV; rden = 1'b1; wren = 1'b1; wdata = 32'd7;
        tick();
        rden = 1'b0; wren = 1'b0;
        check("div_rw_old", rdata, dv);
        rd(A_DIV, rv, rh);
        check("div_rw_new", rv, 7);

        // DIV change in the middle of the start bit
        wr(A_DIV, 32'd8, 4'h0);
        txlog.delete();
        wr(A_TX, 32'h01, 4'h0);
        tick(); tick();
        wr(A_DIV, 32'd3, 4'h0);
        repeat (36) tick();
        got = '0; expv = '0; k = 0;
        for (int j = 0; j < 10; j++) begin
            len = (j == 0) ? 8 : 3;
            for (int c = 0; c < len; c++) begin
                expv[k] = frame_bit(8'h01, j);
                got[k]  = txlog[1+k];
                k++;
            end
        end
        check("div_midbit_frame", got, expv);
        check("div_midbit_busy", busy, 0);

        // Reset during the data phase
        wr(A_DIV, 32'd4, 4'h0);
        wr(A_TX, 32'h00, 4'h0);
        repeat (8) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        rd(A_ST, rv, rh);
        check("midrst_status", rv, 32'h2);
        rd(A_DIV, rv, rh);
        check("midrst_div", rv, DEF_DIV);
        txlog.delete();
        repeat (200) tick();
        zeros = 0;
        foreach (txlog[i]) if (txlog[i] !== 1'b1) zeros++;
        check("midrst_no_residue", zeros, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pinwheel_mmio.md
# pinwheel_mmio

Memory-mapped peripheral block for the pinwheel SoC, replacing the fixed single debug register and stubbed serial path in the top level. It decodes the data bus by address tag and provides a bank of byte-maskable debug registers plus an 8N1 serial transmitter fed by a TX FIFO. The FIFO depth and baud divisor are parametrised, and the divisor can also be changed at runtime. Read data is registered, giving the same one-cycle read latency as block_ram, so the top-level read-return mux treats this block like a RAM.

## Interface
Parameters:
- DEBUG_WORDS, 4: number of 32-bit debug registers; power of 2, 1..16.
- FIFO_DEPTH, 8: TX FIFO entries; power of 2, 2..64.
- CLKS_PER_BIT, 16: reset value of the baud divisor; must be ≥ 2.
- DEBUG_TAG, 4'hF: bus_addr[31:28] value selecting the debug bank.
- SERIAL_TAG, 4'hC: bus_addr[31:28] value selecting the serial registers.

Ports:
- clock, input, 1: sole clock; everything is rising-edge.
- tick_reset_in, input, 1: reset, synchronous, active-high.
- tick_bus_addr, input, 32: byte address from the core.
- tick_bus_rden, input, 1: read strobe.
- tick_bus_wren, input, 1: write strobe.
- tick_bus_wdata, input, 32: write data.
- tick_bus_wmask, input, 4: byte enables; applied to debug registers only.
- rdata_ret, output, 32: registered read data.
- hit_ret, output, 1: registered flag, 1 when the previous cycle's read targeted this block.
- serial_tx, output, 1: UART line; idles high.
- serial_busy, output, 1: 1 while the FIFO is non-empty or a frame is in progress.
- debug_out, output, 32: debug word 0, for the bench and for LEDs.

## Operation
- Select: the block is selected when tick_bus_addr[31:28] is DEBUG_TAG or SERIAL_TAG. Word index = tick_bus_addr[5:2].
- Debug bank:
  - Word index modulo DEBUG_WORDS selects the register.
  - Writes apply tick_bus_wmask per byte.
- Serial register map (offsets are word index 0, 1, 2):
  - 0x0 TXDATA. Write pushes wdata[7:0] into the FIFO. Read returns 0.
  - 0x4 STATUS, read. bit0 full, bit1 empty, bit2 tx_active, bit3 overflow (sticky), bits[15:8] FIFO count.
  - 0x4 STATUS, write. Writing 1 to bit3 clears overflow; other bits are ignored.
  - 0x8 DIV, read/write [15:0]. A written value below 2 is stored as 2.
  - Any other offset reads 0; writes to it are ignored.
- FIFO:
  - A push while full is dropped and sets overflow.
  - A push and a pop in the same cycle while full: the push is accepted and count is unchanged.
  - A push to an empty FIFO is never popped in that same cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the registered count is non-zero. This pops the FIFO head into the shift register and loads the bit counter with DIV.
  - START drives 0 for DIV cycles, then → DATA.
  - DATA sends 8 bits LSB-first, each held for DIV cycles, then → STOP.
  - STOP drives 1 for DIV cycles, then → IDLE. A non-empty FIFO is re-checked in IDLE on the following cycle.
  - A DIV write takes effect at the next bit boundary; the bit in flight keeps its length.
- Reads: rdata_ret and hit_ret update on every edge.
  - Read to an unselected address: rdata_ret=0, hit_ret=0.
  - rden with no selected tag: hit_ret=0.
  - Simultaneous rden and wren to the same register: the write commits, and the read returns the pre-write value.

## Timing
- Reset values: rdata_ret=0, hit_ret=0, serial_tx=1, serial_busy=0, debug_out=0, all debug registers 0, FIFO empty, overflow=0, DIV=CLKS_PER_BIT, FSM=IDLE.
- Reset asserted mid-frame aborts the frame. serial_tx is 1 on the cycle after the reset edge.
- Read latency is 1 cycle: rden at edge N gives rdata_ret/hit_ret valid after edge N.
- Push-to-line latency:
  - TXDATA write sampled at edge N; count becomes 1 after N.
  - FSM enters START at N+1, so serial_tx=0 after edge N+1.
- Frame length is exactly 10×DIV cycles, plus 1 IDLE cycle between back-to-back frames.
- serial_busy is registered and deasserts on the edge where STOP→IDLE occurs with an empty FIFO.

## Structure
- Package pinwheel_mmio_pkg holds:
  - the tx_state_t enum;
  - register offset constants (TXDATA, STATUS, DIV);
  - STATUS bit positions;
  - default tag constants.
- Sub-module sync_fifo(WIDTH, DEPTH): the FIFO storage with count, full, empty, push and pop. It is reused later for RX.
- The top module holds decode, the debug bank, DIV/overflow, the TX FSM and the read mux.

## Test plan
- Reset, then read STATUS: rdata_ret=0x0000_0002 (empty) and hit_ret=1, one cycle after rden. serial_tx=1.
- Debug bank masking: write 0xDEADBEEF to 0xF0000004 with wmask=4'b0011, then read it back → 0x0000BEEF. debug_out remains 0.
- Serial frame: DIV=4, push 0xA5 → serial_tx=0 starts 2 edges after the write. Line reads 1,0,1,0,0,1,0,1 (LSB first) at 4 cycles per bit, then stop=1. serial_busy drops after 40 cycles.
- FIFO overflow: with FIFO_DEPTH=8 and the line stalled by DIV=0xFFFF, push 10 bytes. After the first pop, count settles at 8, the 10th push is dropped and STATUS bit3=1. Writing 0x8 to STATUS clears bit3.
- DIV clamp: write DIV=1, read back → 2. Then a DIV change mid-bit must not alter the current bit length.
- Reset mid-frame: assert reset during DATA → serial_tx=1, count=0, DIV back to CLKS_PER_BIT. No residual bits appear afterward.
